// File: rtl/syncfifo_watermark_pkg.sv
// Shared types for the watermark FIFO slice.
// Selects the source of the registered head-of-queue word.
package syncfifo_watermark_pkg;

  typedef enum logic [1:0] {
    DOUT_HOLD,
    DOUT_DIN,
    DOUT_MEM
  } dout_sel_e;

endpackage

// File: rtl/syncfifo_watermark_if.sv
// Push/pop handshake bundle of the watermark FIFO.
// The producer/consumer side is master, the FIFO is slave.
interface syncfifo_watermark_if #(
  parameter int WID = 32
) ();
  logic           vldin;
  logic [WID-1:0] din;
  logic           full;
  logic           readout;
  logic [WID-1:0] dout;
  logic           empty;

  modport master (
    output vldin, din, readout,
    input  full, dout, empty
  );

  modport slave (
    input  vldin, din, readout,
    output full, dout, empty
  );
endinterface

// File: rtl/syncfifo_watermark_stats.sv
// Occupancy peak, rejected-write counter and sticky error flags.
// A flush freezes all of it; on a clear, same-cycle events still land.
module fifo_stats #(
  parameter int AWID  = 3,
  parameter int DROPW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             softreset,
  input  logic             clear_stats,
  input  logic             wr_rej,
  input  logic             rd_rej,
  input  logic [AWID:0]    next_count,
  output logic [AWID:0]    peak,
  output logic [DROPW-1:0] dropped,
  output logic             ovf_sticky,
  output logic             udf_sticky
);
  localparam logic [DROPW-1:0] DROP_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak       <= '0;
      dropped    <= '0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else if (softreset) begin
      peak       <= peak;
    end else if (clear_stats) begin
      peak       <= next_count;
      dropped    <= wr_rej ? DROPW'(1) : '0;
      ovf_sticky <= wr_rej;
      udf_sticky <= rd_rej;
    end else begin
      if (next_count > peak)
        peak <= next_count;
      if (wr_rej && dropped != DROP_MAX)
        dropped <= dropped + 1'b1;
      ovf_sticky <= ovf_sticky | wr_rej;
      udf_sticky <= udf_sticky | rd_rej;
    end
  end
endmodule

// File: rtl/syncfifo_watermark.sv
// Synchronous FIFO with registered head word, watermarks and statistics.
// Depth need not be a power of two; pointers wrap explicitly.
module syncfifo_watermark
  import syncfifo_watermark_pkg::*;
#(
  parameter int WID   = 32,
  parameter int DEPTH = 8,
  parameter int AWID  = $clog2(DEPTH),
  parameter int DROPW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             softreset,
  syncfifo_watermark_if.slave fif,
  output logic [AWID:0]    count,
  input  logic [AWID:0]    afull_thr,
  input  logic [AWID:0]    aempty_thr,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             ovf_sticky,
  output logic             udf_sticky,
  output logic [AWID:0]    peak,
  output logic [DROPW-1:0] dropped,
  input  logic             clear_stats
);
  localparam int DEPTH1 = DEPTH - 1;
  localparam int AWID1  = AWID - 1;
  localparam logic [AWID1:0] LAST = AWID'(DEPTH1);
  localparam logic [AWID:0]  CFULL = (AWID+1)'(DEPTH);

  logic [WID-1:0]  mem [DEPTH];
  logic [AWID1:0]  wptr, rptr, next_rptr;
  logic [AWID:0]   next_count;
  logic [WID-1:0]  dout_q;
  logic            empty_q;
  logic            full, wr_ok, rd_ok, wr_rej, rd_rej;
  dout_sel_e       dsel;

  function automatic logic [AWID1:0] bump(input logic [AWID1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CFULL);
  assign wr_ok     = fif.vldin && !full;
  assign rd_ok     = fif.readout && !empty_q;
  assign wr_rej    = fif.vldin && full;
  assign rd_rej    = fif.readout && empty_q;
  assign overflow  = wr_rej;
  assign next_rptr = rd_ok ? bump(rptr) : rptr;
  assign fif.full  = full;
  assign fif.empty = empty_q;
  assign fif.dout  = dout_q;

  always_comb begin
    next_count = count;
    if (wr_ok && !rd_ok)
      next_count = count + 1'b1;
    else if (rd_ok && !wr_ok)
      next_count = count - 1'b1;
  end

  // Nothing valid in storage: bypass din so a write into empty shows at once
  always_comb begin
    dsel = DOUT_MEM;
    if (count == '0 || (count == (AWID+1)'(1) && rd_ok))
      dsel = wr_ok ? DOUT_DIN : DOUT_HOLD;
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !softreset)
      mem[wptr] <= fif.din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      empty_q      <= 1'b1;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      dout_q       <= '0;
    end else if (softreset) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      empty_q      <= 1'b1;
      almost_empty <= 1'b1;
      almost_full  <= (afull_thr == '0);
    end else begin
      if (wr_ok)
        wptr <= bump(wptr);
      rptr         <= next_rptr;
      count        <= next_count;
      empty_q      <= (next_count == '0);
      almost_full  <= (next_count >= afull_thr);
      almost_empty <= (next_count <= aempty_thr);
      unique case (dsel)
        DOUT_DIN:  dout_q <= fif.din;
        DOUT_MEM:  dout_q <= mem[next_rptr];
        default:   dout_q <= dout_q;
      endcase
    end
  end

  fifo_stats #(
    .AWID  (AWID),
    .DROPW (DROPW)
  ) u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .softreset   (softreset),
    .clear_stats (clear_stats),
    .wr_rej      (wr_rej),
    .rd_rej      (rd_rej),
    .next_count  (next_count),
    .peak        (peak),
    .dropped     (dropped),
    .ovf_sticky  (ovf_sticky),
    .udf_sticky  (udf_sticky)
  );
endmodule

// File: tb/tb_syncfifo_watermark.sv
// Directed bench: an 8-deep and a 5-deep FIFO driven in sequence.
// Expected values are hand-computed constants and loop-index formulas.
module tb_syncfifo_watermark;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  syncfifo_watermark_if #(.WID(8)) fa ();
  syncfifo_watermark_if #(.WID(8)) fb ();

  logic        sr_a, cs_a, af_a, ae_a, ov_a, os_a, us_a;
  logic [3:0]  cnt_a, pk_a, aft_a, aet_a;
  logic [15:0] dr_a;
  logic        sr_b, cs_b, af_b, ae_b, ov_b, os_b, us_b;
  logic [3:0]  cnt_b, pk_b, aft_b, aet_b;
  logic [15:0] dr_b;

  logic [7:0] exp_a [8];

  syncfifo_watermark #(.WID(8), .DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .softreset(sr_a), .fif(fa),
    .count(cnt_a), .afull_thr(aft_a), .aempty_thr(aet_a),
    .almost_full(af_a), .almost_empty(ae_a), .overflow(ov_a),
    .ovf_sticky(os_a), .udf_sticky(us_a), .peak(pk_a),
    .dropped(dr_a), .clear_stats(cs_a)
  );

  syncfifo_watermark #(.WID(8), .DEPTH(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .softreset(sr_b), .fif(fb),
    .count(cnt_b), .afull_thr(aft_b), .aempty_thr(aet_b),
    .almost_full(af_b), .almost_empty(ae_b), .overflow(ov_b),
    .ovf_sticky(os_b), .udf_sticky(us_b), .peak(pk_b),
    .dropped(dr_b), .clear_stats(cs_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    sr_a = 0; cs_a = 0; aft_a = 4'd6; aet_a = 4'd1;
    fa.vldin = 0; fa.din = '0; fa.readout = 0;
    sr_b = 0; cs_b = 0; aft_b = 4'd5; aet_b = 4'd0;
    fb.vldin = 0; fb.din = '0; fb.readout = 0;
    exp_a[0] = 8'hA5;
    for (int i = 1; i < 8; i++) exp_a[i] = 8'h10 + 8'(i);

    #23;
    chk("rst_count", cnt_a, 0);
    chk("rst_empty", fa.empty, 1);
    chk("rst_aempty", ae_a, 1);
    chk("rst_afull", af_a, 0);
    chk("rst_dout", fa.dout, 0);
    chk("rst_peak", pk_a, 0);
    chk("rst_dropped", dr_a, 0);
    chk("rst_sticky", {os_a, us_a}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single write into empty: zero-bubble head
    fa.vldin = 1; fa.din = 8'hA5;
    tick();
    fa.vldin = 0;
    chk("w1_empty", fa.empty, 0);
    chk("w1_count", cnt_a, 1);
    chk("w1_dout", fa.dout, 8'hA5);
    chk("w1_aempty", ae_a, 1);

    // fill to 8, watching watermarks
    for (int i = 1; i < 8; i++) begin
      fa.vldin = 1; fa.din = exp_a[i];
      tick();
      chk("fill_count", cnt_a, i + 1);
      chk("fill_afull", af_a, (i + 1) >= 6);
      chk("fill_aempty", ae_a, (i + 1) <= 1);
      chk("fill_dout", fa.dout, 8'hA5);
    end
    fa.vldin = 0;
    chk("full_flag", fa.full, 1);

    // extra write while full
    fa.vldin = 1; fa.din = 8'hEE;
    #1;
    chk("ovf_comb", ov_a, 1);
    chk("ovf_full", fa.full, 1);
    tick();
    fa.vldin = 0;
    #1;
    chk("ovf_off", ov_a, 0);
    chk("ovf_dropped", dr_a, 1);
    chk("ovf_sticky", os_a, 1);
    chk("ovf_count", cnt_a, 8);
    chk("ovf_peak", pk_a, 8);
    chk("ovf_dout", fa.dout, 8'hA5);

    // drain, data order intact and 0xEE never stored
    for (int i = 0; i < 8; i++) begin
      fa.readout = 1;
      tick();
      chk("drain_count", cnt_a, 7 - i);
      chk("drain_afull", af_a, (7 - i) >= 6);
      chk("drain_aempty", ae_a, (7 - i) <= 1);
      if (i < 7) chk("drain_dout", fa.dout, exp_a[i + 1]);
    end
    chk("drain_empty", fa.empty, 1);
    chk("drain_peak", pk_a, 8);

    // underflow together with clear_stats
    fa.readout = 1; cs_a = 1;
    tick();
    fa.readout = 0; cs_a = 0;
    chk("udf_sticky", us_a, 1);
    chk("udf_count", cnt_a, 0);
    chk("clr_ovf", os_a, 0);
    chk("clr_dropped", dr_a, 0);
    chk("clr_peak", pk_a, 0);

    // softreset at count 4 with a same-cycle write
    for (int i = 0; i < 4; i++) begin
      fa.vldin = 1; fa.din = 8'h31 + 8'(i);
      tick();
    end
    chk("pre_sr_count", cnt_a, 4);
    fa.din = 8'h99; sr_a = 1;
    tick();
    sr_a = 0; fa.vldin = 0;
    chk("sr_count", cnt_a, 0);
    chk("sr_empty", fa.empty, 1);
    chk("sr_aempty", ae_a, 1);
    chk("sr_afull", af_a, 0);
    chk("sr_peak", pk_a, 4);
    chk("sr_dropped", dr_a, 0);
    fa.vldin = 1; fa.din = 8'h55;
    tick();
    fa.vldin = 0;
    chk("post_sr_dout", fa.dout, 8'h55);
    chk("post_sr_count", cnt_a, 1);

    // DEPTH=5: fill to 3 then 20 cycles of read+write
    for (int i = 1; i <= 3; i++) begin
      fb.vldin = 1; fb.din = 8'(i);
      tick();
    end
    fb.vldin = 0;
    chk("b_count", cnt_b, 3);
    chk("b_dout", fb.dout, 1);
    for (int i = 0; i < 20; i++) begin
      fb.vldin = 1; fb.readout = 1; fb.din = 8'(4 + i);
      tick();
      chk("b_rw_count", cnt_b, 3);
      chk("b_rw_dout", fb.dout, i + 2);
    end
    fb.vldin = 0; fb.readout = 0;
    chk("b_full", fb.full, 0);
    chk("b_peak", pk_b, 3);
    chk("b_dropped", dr_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
